// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares one register-file write port between R
// requesters with a valid/ready handshake and a registered output stage.
// A clear sequencer zero-fills all 2^M registers on a clr pulse.
// Optional macro REGARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of round-robin; the round-robin pointer is removed.
module regfile_write_arbiter #(
    parameter int N = 32,
    parameter int M = 2,
    parameter int R = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R-1:0]         req_valid,
    input  logic [R*M-1:0]       req_id,
    input  logic [R*N-1:0]       req_data,
    output logic [R-1:0]         req_ready,
    input  logic                 hold,
    input  logic                 clr,
    output logic                 clr_busy,
    output logic [M:0]           w1,
    output logic [N-1:0]         w,
    output logic [(1<<M)-1:0]    pending
);

    localparam int PW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [M-1:0]    cnt;
    logic [M-1:0]    cnt_nxt;
    logic [M:0]      w1_q;
    logic [M:0]      w1_nxt;
    logic [N-1:0]    w_q;
    logic [N-1:0]    w_nxt;

    logic [M-1:0]    ids   [R];
    logic [N-1:0]    datas [R];

    logic [R-1:0]    gnt;
    logic            found;
    logic [PW-1:0]   idx;
    logic [M-1:0]    sel_id;
    logic [N-1:0]    sel_data;

`ifndef REGARB_FIXED_PRIO_EN
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
`endif

    // Unpack the flattened per-requester id/data buses.
    always_comb begin
        for (int unsigned k = 0; k < R; k++) begin
            ids[k]   = req_id[k*M +: M];
            datas[k] = req_data[k*N +: N];
        end
    end

    // Grant search: first valid requester from the pointer (or from 0 in
    // fixed-priority builds); no grants in reset, CLEAR, hold or a clr cycle.
    always_comb begin
        gnt      = '0;
        found    = 1'b0;
        idx      = '0;
        sel_id   = '0;
        sel_data = '0;
`ifndef REGARB_FIXED_PRIO_EN
        win      = '0;
`endif
        if (rst && state == S_IDLE && !hold && !clr) begin
            for (int unsigned i = 0; i < R; i++) begin
`ifdef REGARB_FIXED_PRIO_EN
                idx = PW'(i);
`else
                idx = PW'((32'(ptr) + i) % 32'(R));
`endif
                if (!found && req_valid[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    sel_id   = ids[idx];
                    sel_data = datas[idx];
`ifndef REGARB_FIXED_PRIO_EN
                    win      = idx;
`endif
                end
            end
        end
    end

    // Next-state and output-stage load values.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        w1_nxt    = {1'b1, {M{1'b0}}};
        w_nxt     = '0;
        case (state)
            S_IDLE: begin
                if (clr) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end else if (found) begin
                    w1_nxt = {1'b0, sel_id};
                    w_nxt  = sel_data;
                end
            end
            S_CLEAR: begin
                w1_nxt  = {1'b0, cnt};
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, clear counter and output stage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            w1_q  <= {1'b1, {M{1'b0}}};
            w_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            w1_q  <= w1_nxt;
            w_q   <= w_nxt;
        end
    end

`ifndef REGARB_FIXED_PRIO_EN
    // Round-robin pointer: one past the last winner, wrapping at R.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win == PW'(R - 1)) ? '0 : win + 1'b1;
        end
    end
`endif

    // One-hot decode of the register currently being written.
    always_comb begin
        pending = '0;
        if (!w1_q[M]) begin
            pending[w1_q[M-1:0]] = 1'b1;
        end
    end

    assign req_ready = gnt;
    assign clr_busy  = (state == S_CLEAR);
    assign w1        = w1_q;
    assign w         = w_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed table-driven bench for regfile_write_arbiter (N=32, M=2, R=2).
module tb_regfile_write_arbiter;

`ifdef REGARB_FIXED_PRIO_EN
    localparam bit FX = 1'b1;
`else
    localparam bit FX = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [3:0]  req_id;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        hold;
    logic        clr;
    logic        clr_busy;
    logic [2:0]  w1;
    logic [31:0] w;
    logic [3:0]  pending;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter #(.N(32), .M(2), .R(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_id    (req_id),
        .req_data  (req_data),
        .req_ready (req_ready),
        .hold      (hold),
        .clr       (clr),
        .clr_busy  (clr_busy),
        .w1        (w1),
        .w         (w),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  id0;
        logic [1:0]  id1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        hold;
        logic        clr;
        logic [1:0]  rdy;
        logic [2:0]  w1;
        logic [31:0] w;
        logic [3:0]  pend;
        logic        busy;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    localparam logic [31:0] A0 = 32'h0000_00A0;
    localparam logic [31:0] B1 = 32'h0000_00B1;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    task automatic check(input string nm, input int row, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h exp=%0h", nm, row, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] i0, input logic [1:0] i1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic h, input logic c);
        req_valid = v;
        req_id    = {i1, i0};
        req_data  = {d1, d0};
        hold      = h;
        clr       = c;
    endtask

    task automatic check_all(input int row, input logic [1:0] rdy, input logic [2:0] ew1,
                             input logic [31:0] ew, input logic [3:0] pend, input logic busy);
        check("req_ready", row, 64'(req_ready), 64'(rdy));
        check("w1",        row, 64'(w1),        64'(ew1));
        check("w",         row, 64'(w),         64'(ew));
        check("pending",   row, 64'(pending),   64'(pend));
        check("clr_busy",  row, 64'(clr_busy),  64'(busy));
    endtask

    initial begin
        // v, id0, id1, d0, d1, hold, clr | rdy, w1, w, pend, busy
        for (int i = 0; i < 5; i++)
            tbl[i] = '{2'b00, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 3'b100, 32'd0, 4'b0000, 1'b0};
        // single write from requester 0
        tbl[5]  = '{2'b01, 2'd2, 2'd0, DB, 32'd0, 1'b0, 1'b0, 2'b01, 3'b100, 32'd0, 4'b0000, 1'b0};
        tbl[6]  = '{2'b00, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 3'b010, DB, 4'b0100, 1'b0};
        tbl[7]  = '{2'b00, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 3'b100, 32'd0, 4'b0000, 1'b0};
        // both valid, pointer is 1 after the previous grant
        tbl[8]  = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b0, 1'b0, FX ? 2'b01 : 2'b10, 3'b100, 32'd0, 4'b0000, 1'b0};
        tbl[9]  = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b0, 1'b0, 2'b01, FX ? 3'b001 : 3'b011, FX ? A0 : B1, FX ? 4'b0010 : 4'b1000, 1'b0};
        tbl[10] = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b0, 1'b0, FX ? 2'b01 : 2'b10, 3'b001, A0, 4'b0010, 1'b0};
        tbl[11] = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b0, 1'b0, 2'b01, FX ? 3'b001 : 3'b011, FX ? A0 : B1, FX ? 4'b0010 : 4'b1000, 1'b0};
        // hold blocks grants, release grants at the pointer
        tbl[12] = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b1, 1'b0, 2'b00, 3'b001, A0, 4'b0010, 1'b0};
        tbl[13] = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b1, 1'b0, 2'b00, 3'b100, 32'd0, 4'b0000, 1'b0};
        tbl[14] = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b0, 1'b0, FX ? 2'b01 : 2'b10, 3'b100, 32'd0, 4'b0000, 1'b0};
        tbl[15] = '{2'b00, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, FX ? 3'b001 : 3'b011, FX ? A0 : B1, FX ? 4'b0010 : 4'b1000, 1'b0};
        tbl[16] = '{2'b00, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 3'b100, 32'd0, 4'b0000, 1'b0};
        // r2=5, then clear with both requesters waiting
        tbl[17] = '{2'b01, 2'd2, 2'd0, 32'd5, 32'd0, 1'b0, 1'b0, 2'b01, 3'b100, 32'd0, 4'b0000, 1'b0};
        tbl[18] = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b0, 1'b1, 2'b00, 3'b010, 32'd5, 4'b0100, 1'b0};
        tbl[19] = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b0, 1'b0, 2'b00, 3'b100, 32'd0, 4'b0000, 1'b1};
        tbl[20] = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b0, 1'b1, 2'b00, 3'b000, 32'd0, 4'b0001, 1'b1};
        tbl[21] = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b1, 1'b0, 2'b00, 3'b001, 32'd0, 4'b0010, 1'b1};
        tbl[22] = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b0, 1'b0, 2'b00, 3'b010, 32'd0, 4'b0100, 1'b1};
        tbl[23] = '{2'b11, 2'd1, 2'd3, A0, B1, 1'b0, 1'b0, FX ? 2'b01 : 2'b10, 3'b011, 32'd0, 4'b1000, 1'b0};
        tbl[24] = '{2'b00, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, FX ? 3'b001 : 3'b011, FX ? A0 : B1, FX ? 4'b0010 : 4'b1000, 1'b0};
        tbl[25] = '{2'b00, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 3'b100, 32'd0, 4'b0000, 1'b0};

        rst = 1'b0;
        drive(2'b00, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_all(-1, 2'b00, 3'b100, 32'd0, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].v, tbl[i].id0, tbl[i].id1, tbl[i].d0, tbl[i].d1, tbl[i].hold, tbl[i].clr);
            #1;
            check_all(i, tbl[i].rdy, tbl[i].w1, tbl[i].w, tbl[i].pend, tbl[i].busy);
            @(negedge clk);
        end

        // Reset in the middle of a clear sequence.
        drive(2'b01, 2'd3, 2'd0, 32'd77, 32'd0, 1'b0, 1'b0);
        #1;
        check("h_grant", 100, 64'(req_ready), 64'(2'b01));
        @(negedge clk);
        drive(2'b00, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        #1;
        check_all(101, 2'b00, 3'b011, 32'd77, 4'b1000, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_all(102, 2'b00, 3'b100, 32'd0, 4'b0000, 1'b1);
        @(negedge clk);
        #1;
        check_all(103, 2'b00, 3'b000, 32'd0, 4'b0001, 1'b1);
        @(negedge clk);
        #1;
        check_all(104, 2'b00, 3'b001, 32'd0, 4'b0010, 1'b1);
        drive(2'b11, 2'd2, 2'd3, A0, B1, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_all(105, 2'b00, 3'b100, 32'd0, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        check_all(106, 2'b00, 3'b100, 32'd0, 4'b0000, 1'b0);
        rst = 1'b1;
        #1;
        check_all(107, 2'b01, 3'b100, 32'd0, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        check_all(108, FX ? 2'b01 : 2'b10, 3'b010, A0, 4'b0100, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
